// File: rtl/wb_port_arb_if.sv
// Bundle between the writeback sources and the register-file write port:
// per-source request slices going in, one registered write coming out.
interface wb_port_arb_if #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic [PTR_W-1:0]            wr_src;

    // Requester side: raises requests, watches grants and the resulting write.
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, wr_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, wr_src
    );
endinterface

// File: rtl/wb_port_arb.sv
// Round-robin arbiter that shares one register-file write port among N_REQ
// writeback sources; the winning request is written one cycle after handshake.
module wb_port_arb #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter bit DROP_ZERO  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_aL,
    input  logic                       init,
    input  logic [$clog2(N_REQ)-1:0]   init_ptr,
    input  logic                       flush,
    wb_port_arb_if.slave               bus,
    output logic [15:0]                conflict_cnt
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0]   N_EXT = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]      ptr_reg, ptr_next;
    logic                  wr_en_reg, wr_en_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
    logic [PTR_W-1:0]      wr_src_reg, wr_src_next;
    logic [15:0]           conflict_cnt_reg, conflict_cnt_next;

    logic [ADDR_WIDTH-1:0] addr_slice [N_REQ];
    logic [DATA_WIDTH-1:0] data_slice [N_REQ];
    logic [PTR_W-1:0]      rot_idx    [N_REQ];
    logic [N_REQ-1:0]      rot_valid;
    logic [N_REQ-1:0]      ready_vec;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  xfer;
    logic                  multi_valid;
    logic [PTR_W-1:0]      init_ptr_safe;

    // rot_idx[k] is the requester k places behind the priority pointer, so a
    // plain lowest-index priority scan over rot_valid implements round-robin.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [PTR_W:0] rot_sum;

            assign addr_slice[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign data_slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rot_sum        = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign rot_idx[gi]    = (rot_sum >= N_EXT) ? PTR_W'(rot_sum - N_EXT)
                                                       : rot_sum[PTR_W-1:0];
            assign rot_valid[gi]  = bus.req_valid[rot_idx[gi]];
            assign ready_vec[gi]  = xfer && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        // Scan from the far end so the entry closest to the pointer wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = rot_idx[k];
            end
        end
    end

    assign xfer          = grant_any && !flush;
    assign multi_valid   = ($countones(bus.req_valid) > 1);
    assign init_ptr_safe = (init_ptr > LAST) ? '0 : init_ptr;

    always_comb begin
        ptr_next          = ptr_reg;
        wr_en_next        = 1'b0;
        wr_addr_next      = wr_addr_reg;
        wr_data_next      = wr_data_reg;
        wr_src_next       = wr_src_reg;
        conflict_cnt_next = conflict_cnt_reg;
        if (xfer) begin
            ptr_next     = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            wr_addr_next = addr_slice[grant_idx];
            wr_data_next = data_slice[grant_idx];
            wr_src_next  = grant_idx;
            // Writes to register 0 are consumed but never reach the file.
            wr_en_next   = !(DROP_ZERO && (addr_slice[grant_idx] == '0));
        end
        if (multi_valid && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_next = conflict_cnt_reg + 16'd1;
        end
    end

    // init overrides reset so a test can start from any priority position.
    always_ff @(posedge clk or negedge rst_aL or posedge init) begin
        if (init) begin
            ptr_reg          <= init_ptr_safe;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
            wr_src_reg       <= '0;
            conflict_cnt_reg <= '0;
        end else if (!rst_aL) begin
            ptr_reg          <= '0;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
            wr_src_reg       <= '0;
            conflict_cnt_reg <= '0;
        end else begin
            ptr_reg          <= ptr_next;
            wr_en_reg        <= wr_en_next;
            wr_addr_reg      <= wr_addr_next;
            wr_data_reg      <= wr_data_next;
            wr_src_reg       <= wr_src_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.wr_src    = wr_src_reg;
    assign conflict_cnt  = conflict_cnt_reg;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_aL || init)
        $onehot0(bus.req_ready));
    a_ready_valid: assert property (@(posedge clk) disable iff (!rst_aL || init)
        (bus.req_ready & ~bus.req_valid) == '0);
    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_aL || init)
        ptr_reg <= LAST);
endmodule

// File: tb/tb_wb_port_arb.sv
// Randomized and directed bench for wb_port_arb against a queue-free
// behavioural model of the round-robin write-port sharing rules.
module tb_wb_port_arb;
    localparam int N  = 3;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int PW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          init;
    logic [PW-1:0] init_ptr;
    logic          flush;
    logic [15:0]   conflict_cnt;

    wb_port_arb_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_port_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_ZERO(1'b1)) dut (
        .clk          (clk),
        .rst_aL       (rst_aL),
        .init         (init),
        .init_ptr     (init_ptr),
        .flush        (flush),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Requester-side state: each source holds its request until granted.
    bit            pend  [N];
    logic [AW-1:0] raddr [N];
    logic [DW-1:0] rdata [N];

    // Reference model state.
    int            m_ptr;
    bit            m_wr_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int ptr0);
        m_ptr   = ptr0;
        m_wr_en = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_src   = 0;
        m_cnt   = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]            = pend[i];
            bus.req_addr[i*AW +: AW]    = raddr[i];
            bus.req_data[i*DW +: DW]    = rdata[i];
        end
    endtask

    task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        raddr[i] = a;
        rdata[i] = d;
    endtask

    task automatic arrive(input int pct, input bit allow_zero);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(99) < pct)) begin
                if (allow_zero && ($urandom_range(7) == 0))
                    put(i, '0, $urandom);
                else
                    put(i, AW'($urandom_range(63, 1)), $urandom);
            end
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_wr_en"},   64'(bus.wr_en),      64'(m_wr_en));
        chk({tag, "_wr_addr"}, 64'(bus.wr_addr),    64'(m_addr));
        chk({tag, "_wr_data"}, 64'(bus.wr_data),    64'(m_data));
        chk({tag, "_wr_src"},  64'(bus.wr_src),     64'(m_src));
        chk({tag, "_cnt"},     64'(conflict_cnt),   64'(m_cnt));
        chk({tag, "_ptr"},     64'(dut.ptr_reg),    64'(m_ptr));
    endtask

    // One clock of traffic: ready is checked before the edge, registered
    // outputs just after it.
    task automatic step(input bit fl, input bit chk_on);
        int g;
        int nv;
        logic [N-1:0] exp_ready;
        flush = fl;
        drive();
        #1;
        g  = -1;
        nv = 0;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (pend[k]) nv++;
        end
        exp_ready = '0;
        if (g >= 0 && !fl) exp_ready[g] = 1'b1;
        if (chk_on) chk("ready", 64'(bus.req_ready), 64'(exp_ready));
        @(posedge clk);
        if (g >= 0 && !fl) begin
            m_wr_en = (raddr[g] != '0);
            m_addr  = raddr[g];
            m_data  = rdata[g];
            m_src   = g;
            m_ptr   = (g + 1) % N;
            pend[g] = 1'b0;
        end else begin
            m_wr_en = 1'b0;
        end
        if (nv >= 2 && m_cnt < 65535) m_cnt++;
        #1;
        if (chk_on) begin
            check_regs("step");
            $display("xfer t=%0t flush=%0b valid=%b ready=%b wr_en=%0b src=%0d addr=%0h data=%0h cnt=%0d",
                     $time, fl, bus.req_valid, bus.req_ready, bus.wr_en, bus.wr_src,
                     bus.wr_addr, bus.wr_data, conflict_cnt);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((pend[0] || pend[1] || pend[2]) && guard < 10) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("drain_done", 64'(pend[0] | pend[1] | pend[2]), 64'(0));
    endtask

    initial begin
        int c0;
        n_vec    = 0;
        n_err    = 0;
        rst_aL   = 1'b0;
        init     = 1'b0;
        init_ptr = '0;
        flush    = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            raddr[i] = '0;
            rdata[i] = '0;
        end
        drive();
        model_reset(0);
        #12;
        check_regs("reset");
        rst_aL = 1'b1;

        // All three requesting continuously: strict rotation 0,1,2,0...
        for (int c = 0; c < 6; c++) begin
            arrive(100, 1'b0);
            step(1'b0, 1'b1);
        end
        drain();

        // Lone requester 2: granted every cycle, pointer returns to 0.
        for (int c = 0; c < 4; c++) begin
            put(2, AW'(c + 5), DW'(32'h2000 + c));
            step(1'b0, 1'b1);
            chk("lone_ptr", 64'(dut.ptr_reg), 64'(0));
        end

        // Flush blocks a grant for one cycle, then arbitration resumes.
        put(0, 6'h11, 32'hA0A0_0000);
        put(1, 6'h12, 32'hB1B1_0000);
        c0 = int'(dut.ptr_reg);
        step(1'b1, 1'b1);
        chk("flush_ptr_hold", 64'(dut.ptr_reg), 64'(c0));
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        drain();

        // Address 0 is accepted but suppressed.
        put(1, 6'h00, 32'hDEAD);
        step(1'b0, 1'b1);
        chk("drop_wr_en", 64'(bus.wr_en), 64'(0));
        chk("drop_ptr",   64'(dut.ptr_reg), 64'(2));

        // Three cycles with two sources valid adds exactly three.
        c0 = int'(conflict_cnt);
        for (int c = 0; c < 3; c++) begin
            arrive(0, 1'b0);
            if (!pend[1]) put(1, AW'($urandom_range(63, 1)), $urandom);
            if (!pend[2]) put(2, AW'($urandom_range(63, 1)), $urandom);
            step(1'b0, 1'b1);
        end
        chk("conflict3", 64'(conflict_cnt - 16'(c0)), 64'(3));
        drain();

        // Asynchronous reset while a write is on the port.
        put(0, 6'h2A, 32'h1234_5678);
        step(1'b0, 1'b1);
        chk("pre_reset_wr_en", 64'(bus.wr_en), 64'(1));
        #2;
        rst_aL = 1'b0;
        #1;
        model_reset(0);
        check_regs("async_rst");
        #1;
        rst_aL = 1'b1;

        // Asynchronous init loads the pointer; first grant goes to requester 2.
        #1;
        init_ptr = 2'd2;
        init     = 1'b1;
        #1;
        chk("init_ptr2", 64'(dut.ptr_reg), 64'(2));
        init = 1'b0;
        model_reset(2);
        arrive(100, 1'b0);
        step(1'b0, 1'b1);
        chk("init_first_src", 64'(bus.wr_src), 64'(2));

        // Out-of-range init pointer falls back to 0.
        init_ptr = 2'd3;
        init     = 1'b1;
        #1;
        model_reset(0);
        check_regs("init_oor");
        init = 1'b0;
        drain();

        // Random traffic with occasional flushes and zero addresses.
        for (int c = 0; c < 400; c++) begin
            arrive(45, 1'b1);
            step(($urandom_range(9) == 0), 1'b1);
        end
        drain();

        // Keep all sources busy long enough to saturate the conflict counter.
        for (int c = 0; c < 65545; c++) begin
            arrive(100, 1'b0);
            step(1'b0, (c >= 65530));
        end
        chk("cnt_sat", 64'(conflict_cnt), 64'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
